// File: rtl/nios2_oci_pkg.sv
// rtl/nios2_oci_pkg.sv - shared state encoding and full-policy constants for OCI trace capture
package nios2_oci_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

    localparam int WRAP_DROP      = 0;
    localparam int WRAP_OVERWRITE = 1;

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// rtl/nios2_oci_trace_ram.sv - register-array trace store, synchronous write, asynchronous read
module nios2_oci_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// rtl/nios2_oci_trace_capture.sv - circular trace buffer: capture, drain over valid/ready, sticky done
module nios2_oci_trace_capture
    import nios2_oci_pkg::*;
#(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16,
    parameter int WRAP    = 0,
    parameter int DROP_W  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1,
    localparam int ENT_W  = DATA_W + COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  dct_buffer,
    input  logic [COUNT_W-1:0] dct_count,
    input  logic               dct_valid,
    input  logic               test_ending,
    input  logic               test_has_ended,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENT_W-1:0]   rd_data,
    output logic [LVL_W-1:0]   level,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic [1:0]         state,
    output logic               done
);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                ram_we;
    logic                full;
    logic                empty;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        ram_we     = 1'b0;

        // Abort wins over everything else in the cycle: no write, no pop.
        if (test_has_ended) begin
            state_d = ST_DONE;
        end else begin
            unique case (state_q)
                ST_CAPTURE: begin
                    if (dct_valid) begin
                        if (!full) begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            level_d  = level_q + LVL_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                            if (drop_cnt_q != '1) begin
                                drop_cnt_d = drop_cnt_q + DROP_W'(1);
                            end
                            // Overwrite the oldest slot; level stays pinned at DEPTH.
                            if (WRAP == WRAP_OVERWRITE) begin
                                ram_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                            end
                        end
                    end
                    if (test_ending) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (empty) begin
                        state_d = ST_DONE;
                    end else if (rd_ready) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        level_d  = level_q - LVL_W'(1);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_CAPTURE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CAPTURE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    nios2_oci_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata ({dct_count, dct_buffer}),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign rd_valid = (state_q == ST_DRAIN) && !empty;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign state    = state_q;
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// tb/tb_nios2_oci_trace_capture.sv - self-checking bench, drop and overwrite instances against a queue model
module tb_nios2_oci_trace_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_ready;

    logic        rv_w    [2];
    logic [33:0] rdata_w [2];
    logic [4:0]  lvl_w   [2];
    logic        ovf_w   [2];
    logic [15:0] drop_w  [2];
    logic [1:0]  st_w    [2];
    logic        done_w  [2];

    int vectors = 0;
    int miscompares = 0;

    // behavioural model: one queue per instance, index 0 drops, index 1 overwrites
    logic [33:0] mq [2][$];
    logic [1:0]  mst   [2];
    logic        movf  [2];
    logic [15:0] mdrop [2];

    always #5 clk = ~clk;

    nios2_oci_trace_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(16), .WRAP(0), .DROP_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rv_w[0]), .rd_data(rdata_w[0]), .level(lvl_w[0]),
        .overflow(ovf_w[0]), .drop_cnt(drop_w[0]), .state(st_w[0]), .done(done_w[0])
    );

    nios2_oci_trace_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(16), .WRAP(1), .DROP_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rv_w[1]), .rd_data(rdata_w[1]), .level(lvl_w[1]),
        .overflow(ovf_w[1]), .drop_cnt(drop_w[1]), .state(st_w[1]), .done(done_w[1])
    );

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0h, expected %0h", nm, inst, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic [33:0] ent,
                                input logic te, input logic th, input logic rr);
        for (int j = 0; j < 2; j++) begin
            if (r) begin
                mq[j].delete();
                mst[j]   = 2'b00;
                movf[j]  = 1'b0;
                mdrop[j] = 16'h0;
            end else if (th) begin
                mst[j] = 2'b10;
            end else if (mst[j] == 2'b00) begin
                if (v) begin
                    if (mq[j].size() < 16) begin
                        mq[j].push_back(ent);
                    end else begin
                        movf[j] = 1'b1;
                        if (mdrop[j] != 16'hFFFF) mdrop[j] = mdrop[j] + 16'h1;
                        if (j == 1) begin
                            void'(mq[j].pop_front());
                            mq[j].push_back(ent);
                        end
                    end
                end
                if (te) mst[j] = 2'b01;
            end else if (mst[j] == 2'b01) begin
                if (mq[j].size() == 0) mst[j] = 2'b10;
                else if (rr) void'(mq[j].pop_front());
            end
        end
    endtask

    task automatic model_check();
        for (int j = 0; j < 2; j++) begin
            logic exp_rv;
            exp_rv = (mst[j] == 2'b01) && (mq[j].size() != 0);
            chk("m_state", j, 64'(st_w[j]), 64'(mst[j]));
            chk("m_level", j, 64'(lvl_w[j]), 64'(mq[j].size()));
            chk("m_rd_valid", j, 64'(rv_w[j]), 64'(exp_rv));
            chk("m_overflow", j, 64'(ovf_w[j]), 64'(movf[j]));
            chk("m_drop_cnt", j, 64'(drop_w[j]), 64'(mdrop[j]));
            chk("m_done", j, 64'(done_w[j]), 64'(mst[j] == 2'b10));
            if (exp_rv) chk("m_rd_data", j, 64'(rdata_w[j]), 64'(mq[j][0]));
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [29:0] b, input logic [3:0] c,
                        input logic te, input logic th, input logic rr);
        reset          = r;
        dct_valid      = v;
        dct_buffer     = b;
        dct_count      = c;
        test_ending    = te;
        test_has_ended = th;
        rd_ready       = rr;
        model_update(r, v, {c, b}, te, th, rr);
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic        rst;
        logic        v;
        logic        te;
        logic        rr;
        logic [29:0] b;
        int          lvl;
        logic [1:0]  st;
        logic        rv;
        logic [33:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic v, input logic te, input logic rr,
                       input logic [29:0] b, input int lvl, input logic [1:0] st,
                       input logic rv, input logic [33:0] d);
        vec_t t;
        t.rst = rst; t.v = v; t.te = te; t.rr = rr; t.b = b;
        t.lvl = lvl; t.st = st; t.rv = rv; t.data = d;
        tbl.push_back(t);
    endtask

    initial begin
        int idx [2];
        int pat [6];
        int pops;
        logic [33:0] prev;
        logic [4:0]  lb;

        for (int j = 0; j < 2; j++) begin
            mst[j] = 2'b00; movf[j] = 1'b0; mdrop[j] = 16'h0;
        end
        reset = 1'b1; dct_buffer = '0; dct_count = '0; dct_valid = 1'b0;
        test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
        @(negedge clk);

        // basic capture of 5 words then drain with rd_ready held high
        add(1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 0, 2'b00, 1'b0, 34'h0);
        for (int k = 1; k <= 5; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 30'(k), k, 2'b00, 1'b0, 34'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 30'h0, 5, 2'b01, 1'b1, {4'h3, 30'h1});
        for (int k = 2; k <= 5; k++) add(1'b0, 1'b0, 1'b0, 1'b1, 30'h0, 6 - k, 2'b01, 1'b1, {4'h3, 30'(k)});
        add(1'b0, 1'b0, 1'b0, 1'b1, 30'h0, 0, 2'b01, 1'b0, 34'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 30'h0, 0, 2'b10, 1'b0, 34'h0);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].b, 4'h3, tbl[i].te, 1'b0, tbl[i].rr);
            for (int j = 0; j < 2; j++) begin
                chk("tbl_level", j, 64'(lvl_w[j]), 64'(tbl[i].lvl));
                chk("tbl_state", j, 64'(st_w[j]), 64'(tbl[i].st));
                chk("tbl_rd_valid", j, 64'(rv_w[j]), 64'(tbl[i].rv));
                if (tbl[i].rv) chk("tbl_rd_data", j, 64'(rdata_w[j]), 64'(tbl[i].data));
            end
        end

        // 20 writes into 16 entries: instance 0 keeps 0..15, instance 1 keeps 4..19
        step(1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 30'(k), 4'(k), 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            chk("ovf_level", j, 64'(lvl_w[j]), 64'd16);
            chk("ovf_flag", j, 64'(ovf_w[j]), 64'd1);
            chk("ovf_drop_cnt", j, 64'(drop_w[j]), 64'd4);
        end
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        idx[0] = 0; idx[1] = 0;
        for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < 2; j++) begin
                if (rv_w[j]) begin
                    chk("ovf_drain_order", j, 64'(rdata_w[j][29:0]), 64'(idx[j] + 4 * j));
                    idx[j]++;
                end
            end
            step(1'b0, 1'b1, 30'h3FF, 4'h0, 1'b0, 1'b0, 1'b1);
        end
        for (int j = 0; j < 2; j++) begin
            chk("ovf_drain_count", j, 64'(idx[j]), 64'd16);
            chk("ovf_done", j, 64'(done_w[j]), 64'd1);
        end

        // reset while in DONE with overflow and drops recorded
        step(1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            chk("rst_state", j, 64'(st_w[j]), 64'd0);
            chk("rst_level", j, 64'(lvl_w[j]), 64'd0);
            chk("rst_overflow", j, 64'(ovf_w[j]), 64'd0);
            chk("rst_drop_cnt", j, 64'(drop_w[j]), 64'd0);
            chk("rst_rd_valid", j, 64'(rv_w[j]), 64'd0);
            chk("rst_done", j, 64'(done_w[j]), 64'd0);
        end

        // backpressure: rd_ready 1,0,0,1,0,1 over 3 entries
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 30'(12'h100 + k), 4'h5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        pat = '{1, 0, 0, 1, 0, 1};
        pops = 0;
        for (int n = 0; n < 6; n++) begin
            prev = rdata_w[0];
            lb   = lvl_w[0];
            if (pat[n] != 0) chk("bp_pop_data", 0, 64'(prev), 64'({4'h5, 30'(12'h100 + pops)}));
            step(1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'(pat[n]));
            if (pat[n] == 0) chk("bp_hold", 0, 64'(rdata_w[0]), 64'(prev));
            if (lvl_w[0] != lb) pops++;
        end
        chk("bp_pops", 0, 64'(pops), 64'd3);
        chk("bp_level", 0, 64'(lvl_w[0]), 64'd0);

        // abort in DRAIN with level 8, rd_ready high: no pop
        step(1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 30'(k), 4'h1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 2; j++) begin
            chk("abort_state", j, 64'(st_w[j]), 64'd2);
            chk("abort_level", j, 64'(lvl_w[j]), 64'd8);
            chk("abort_rd_valid", j, 64'(rv_w[j]), 64'd0);
        end
        step(1'b0, 1'b1, 30'h7, 4'h7, 1'b1, 1'b0, 1'b1);
        chk("done_frozen_level", 0, 64'(lvl_w[0]), 64'd8);

        // test_ending with empty buffer: DONE two edges later
        step(1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("empty_end_drain", 0, 64'(st_w[0]), 64'd1);
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("empty_end_done", 0, 64'(st_w[0]), 64'd2);

        // write in the same cycle as test_ending is captured
        step(1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 30'h2A, 4'h9, 1'b1, 1'b0, 1'b0);
        chk("end_write_level", 0, 64'(lvl_w[0]), 64'd1);
        chk("end_write_data", 0, 64'(rdata_w[0]), 64'({4'h9, 30'h2A}));
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("end_write_done", 0, 64'(done_w[0]), 64'd1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 30'($urandom),
                 4'($urandom), ($urandom_range(0, 23) == 0), ($urandom_range(0, 127) == 0),
                 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nios2_oci_trace_capture.md
# nios2_oci_trace_capture

Parametrised trace-capture block for the Nios II on-chip-instrumentation (OCI) debug path. It buffers debug-core trace words and their accompanying 4-bit count into an on-chip circular buffer during a test. On test end it drains them through a valid/ready read port and then reaches a sticky DONE state. It sits beside the OCI debug module in simulation and debug builds. Unlike a passive sink, it stores, counts and reports overflow of trace traffic.

## Interface
Parameters:
- DATA_W, 30, width of trace word dct_buffer
- COUNT_W, 4, width of dct_count
- DEPTH, 16, buffer entries; power of two, ≥2
- WRAP, 0, full policy: 0 = drop new words, 1 = overwrite oldest
- DROP_W, 16, width of saturating drop/overwrite counter

Ports:
- clk  in  1  single clock; everything is on its rising edge
- reset  in  1  synchronous, active-high reset
- dct_buffer  in  DATA_W  trace word
- dct_count  in  COUNT_W  trace count tag stored with word
- dct_valid  in  1  capture strobe; one entry per cycle when high
- test_ending  in  1  request end of capture and start drain
- test_has_ended  in  1  abort; force DONE immediately
- rd_ready  in  1  consumer accepts rd_data
- rd_valid  out  1  rd_data holds oldest entry (DRAIN only)
- rd_data  out  DATA_W+COUNT_W  {dct_count, dct_buffer} of oldest entry
- level  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: a write hit a full buffer
- drop_cnt  out  DROP_W  saturating count of dropped or overwritten entries
- state  out  2  00 CAPTURE, 01 DRAIN, 10 DONE
- done  out  1  state == DONE

## Operation
- Reset values: state CAPTURE, level 0, overflow 0, drop_cnt 0, rd_valid 0, done 0. Pointers are 0 and memory contents are don't-care. rd_data is don't-care while rd_valid is 0.
- CAPTURE:
  - dct_valid writes {dct_count, dct_buffer} at wr_ptr; level increments.
  - Reads are disabled and rd_valid is 0.
  - test_ending moves the state to DRAIN. A dct_valid in that same cycle is still captured.
- DRAIN:
  - Writes are ignored and do not count as drops.
  - rd_valid = (level ≠ 0). A pop occurs when rd_valid & rd_ready; rd_ptr advances and level decrements.
  - When level reaches 0, or is already 0 on entry, the next cycle moves to DONE.
- DONE: sticky until reset. rd_valid is 0, writes are ignored, and level, overflow and drop_cnt are frozen.
- test_has_ended in any state forces DONE on the next edge. It takes priority over test_ending, writes and pops in the same cycle: no write, no pop.
- Full, WRAP=0: a write at level==DEPTH is discarded. overflow is set and drop_cnt increments, saturating at all-ones.
- Full, WRAP=1: a write at level==DEPTH overwrites the oldest entry. Both pointers advance, level stays at DEPTH, overflow is set and drop_cnt increments.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. level is a separate counter so full and empty are unambiguous.
- reset mid-DRAIN or mid-DONE returns the block to the reset state on the next edge. Buffered data is lost.

## Timing
- A write at edge N is reflected in level after edge N. In DRAIN, the entry appears on rd_data at edge N+1 at the earliest.
- rd_data and rd_valid are driven combinationally from registered pointers and memory (first-word fall-through). There is no combinational path from rd_ready to rd_valid or rd_data.
- The pop is taken on the edge where rd_valid & rd_ready are high. The next entry is presented in the following cycle.
- Throughput: 1 write per cycle in CAPTURE and 1 pop per cycle in DRAIN.
- State change latency is one edge for test_ending and for test_has_ended. DRAIN→DONE occurs one edge after level==0.

## Structure
- Shared package nios2_oci_pkg holds the state encoding constants (ST_CAPTURE=2'b00, ST_DRAIN=2'b01, ST_DONE=2'b10) and the WRAP policy constants.
- One sub-module, nios2_oci_trace_ram: DEPTH×(DATA_W+COUNT_W) register array with a synchronous write port and an asynchronous read port.
- The FSM, pointers, level and counters live in the top module.

## Test plan
- Basic: write 5 entries (dct_buffer 0x1..0x5, dct_count 0x3), pulse test_ending, hold rd_ready=1. Expect 5 pops in order at one per cycle, with rd_data {4'h3,30'h1}..{4'h3,30'h5}. DONE follows one cycle after level=0.
- Overflow drop, WRAP=0, DEPTH=16: write 20 entries 0..19. Expect level=16, overflow=1, drop_cnt=4, and drain yields 0..15.
- Overwrite, WRAP=1, DEPTH=16: write 20 entries 0..19. Expect level=16, overflow=1, drop_cnt=4, and drain yields 4..19.
- Backpressure: drain 3 entries with rd_ready toggling 1,0,0,1,0,1. Expect rd_data held stable while rd_ready=0, exactly 3 pops, and no duplicates.
- Abort: in DRAIN with level=8, assert test_has_ended together with rd_ready=1. Expect DONE next edge, level frozen at 8 (no pop), rd_valid=0.
- Edge cases:
  - test_ending with level=0 → DONE two edges later.
  - dct_valid together with test_ending → entry captured.
  - reset asserted in DONE → all outputs at reset values next edge.
